ahb_mem_slave: RTL

AHB-Lite responder sitting behind the AHB decoder: one instance per 1 KB slave window, selected by its bit of the decoder's slave select vector. It holds a small word-addressed register memory and answers read/write transfers with HREADYOUT/HRESP. It inserts programmable wait states and returns the two-cycle ERROR response for illegal accesses. This is the slave end of the bus the decoder steers.

---
 rtl/ahb_mem_slave_if.sv | 29 ++
 rtl/ahb_mem_slave.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus signals between the decoder/master side and one ahb_mem_slave.
// ahb_ready_in is the HREADY returned by the bus response mux, so the master
// side drives it towards the slave.
interface ahb_mem_slave_if #(
    parameter int AHB_ADDR_WIDTH = 32
);
    logic                      ahb_sel_in;
    logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
    logic [1:0]                ahb_trans_in;
    logic                      ahb_write_in;
    logic [2:0]                ahb_size_in;
    logic [31:0]               ahb_wdata_in;
    logic                      ahb_ready_in;
    logic                      ahb_readyout_out;
    logic                      ahb_resp_out;
    logic [31:0]               ahb_rdata_out;

    modport master (
        output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in,
               ahb_size_in, ahb_wdata_in, ahb_ready_in,
        input  ahb_readyout_out, ahb_resp_out, ahb_rdata_out
    );

    modport slave (
        input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_write_in,
               ahb_size_in, ahb_wdata_in, ahb_ready_in,
        output ahb_readyout_out, ahb_resp_out, ahb_rdata_out
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave for one 1 KB window: flop-based word memory with
// byte/halfword/word writes, two-cycle ERROR response for illegal accesses.
// Optional feature macro: AHB_SLAVE_WAIT_EN -- when defined every OKAY
// transfer takes WAIT_CYCLES wait states; when undefined all OKAY transfers
// are zero-wait and no wait counter is built.
module ahb_mem_slave #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH      = 128,
    parameter int WAIT_CYCLES    = 2
) (
    input logic             ahb_clk_in,
    input logic             ahb_rstn_in,
    ahb_mem_slave_if.slave  ahb
);
    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic              accept, capture, addr_err;
    logic [3:0]        wait_cnt;
    logic [9:0]        addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        byte_en;
    logic [31:0]       mem [MEM_DEPTH];

    // Only the window offset and the NONSEQ/SEQ bit of HTRANS matter here.
    wire unused_ok = &{1'b0, ahb.ahb_addr_in[AHB_ADDR_WIDTH-1:10],
                       ahb.ahb_trans_in[0], addr_q};

`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
    assign wait_cnt = 4'(WAIT_CYCLES);

    // Wait-state down-counter, loaded when an OKAY transfer is accepted.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end
`else
    localparam int UNUSED_WAIT_CYCLES = WAIT_CYCLES;
    assign wait_cnt = 4'd0;
`endif

    // Address-phase acceptance and legality of the offered access.
    always_comb begin
        accept   = ahb.ahb_sel_in & ahb.ahb_ready_in & ahb.ahb_trans_in[1];
        addr_err = 1'b0;
        if (ahb.ahb_size_in > 3'd2)                                   addr_err = 1'b1;
        if (ahb.ahb_size_in == 3'd1 && ahb.ahb_addr_in[0])            addr_err = 1'b1;
        if (ahb.ahb_size_in == 3'd2 && ahb.ahb_addr_in[1:0] != 2'b00) addr_err = 1'b1;
        if ({1'b0, ahb.ahb_addr_in[9:2]} >= DEPTH_LIM)                addr_err = 1'b1;
    end

    // Next-state logic; WAIT and ERR1 are stall states that ignore the bus.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    capture = 1'b1;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (wait_cnt != 4'd0) begin
                        state_d = ST_WAIT;
`ifdef AHB_SLAVE_WAIT_EN
                        cnt_d   = wait_cnt;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
`ifdef AHB_SLAVE_WAIT_EN
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DATA;
`else
                state_d = ST_DATA;
`endif
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Address-phase control captured for the following data phase.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else if (capture) begin
            addr_q  <= ahb.ahb_addr_in[9:0];
            write_q <= ahb.ahb_write_in;
            size_q  <= ahb.ahb_size_in;
        end
    end

    assign idx = addr_q[IDX_W+1:2];

    // Little-endian byte lanes for the registered size/offset.
    always_comb begin
        case (size_q)
            3'd0:    byte_en = 4'b0001 << addr_q[1:0];
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Memory: cleared on reset, written only at the end of an OKAY write data phase.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[idx][8*b +: 8] <= ahb.ahb_wdata_in[8*b +: 8];
        end
    end

    // Response outputs decoded from the current state.
    always_comb begin
        ahb.ahb_readyout_out = !(state_q == ST_WAIT || state_q == ST_ERR1);
        ahb.ahb_resp_out     = (state_q == ST_ERR1 || state_q == ST_ERR2);
        ahb.ahb_rdata_out    = (state_q == ST_DATA && !write_q) ? mem[idx] : 32'd0;
    end
endmodule
